div_seq_8088: RTL and testbench
===============================

Name: div_seq_8088

Overview:
- Sequential shift-subtract divider for the 8088 ALU's DIV/IDIV path. It is the inverse of the add/multiply datapath.
- Takes a 2*WIDTH-bit dividend (DX:AX) and a WIDTH-bit divisor. Produces quotient (AX) and remainder (DX), one quotient bit per clock.
- Flags the 8088 divide error (INT 0 condition) for a zero divisor or quotient overflow.
- Sits beside the combinational adder and is driven by the execution-unit sequencer with a START/DONE handshake.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width; the dividend is 2*WIDTH bits (8-bit DIV uses WIDTH=8).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  begin a division; sampled only in IDLE.
- SIGNED  input  1  1=IDIV (two's complement), 0=DIV; captured with START.
- DIVIDEND  input  2*WIDTH  DX:AX; captured with START.
- DIVISOR  input  WIDTH  captured with START.
- BUSY  output  1  high from the cycle after START is accepted until DONE, inclusive.
- DONE  output  1  one-cycle pulse: Q/REM/DE are valid.
- Q  output  WIDTH  quotient, registered.
- REM  output  WIDTH  remainder, registered.
- DE  output  1  divide error, registered; held until the next accepted START.

Behaviour:
- Reset: asynchronous, active-high. Forces state=IDLE and BUSY=DONE=DE=0, Q=REM=0. Reset mid-operation aborts with no DONE pulse.
- States and transitions:
  - IDLE: if START=1, capture operands and go to CHECK. Otherwise stay.
  - CHECK (1 cycle):
    - If SIGNED=1, form magnitudes of dividend and divisor. Record qneg = sign(dividend) XOR sign(divisor) and rneg = sign(dividend).
    - Error if divisor magnitude = 0, or upper WIDTH bits of the dividend magnitude >= divisor magnitude.
    - On error, go to DONE with DE=1. Q/REM keep their previous values.
    - Otherwise load the partial remainder with the upper half and the shift register with the lower half, clear the bit counter, and go to RUN.
  - RUN (exactly WIDTH cycles): restoring step per cycle.
    - t = {prem, msb(shift)} minus divisor, computed on WIDTH+1 bits.
    - If t is non-negative, prem = t and the quotient bit is 1; otherwise prem is shifted unchanged and the bit is 0.
    - The counter wraps from WIDTH-1 into FIX.
  - FIX (1 cycle):
    - Apply signs: Q = -q if qneg, REM = -r if rneg.
    - Signed range check follows 8086/8088 IDIV. The legal quotient is -(2^(WIDTH-1)-1) to +(2^(WIDTH-1)-1). Magnitude >= 2^(WIDTH-1) sets DE=1 and leaves Q/REM unchanged.
    - Go to DONE.
  - DONE (1 cycle): DONE=1, BUSY=1, then return to IDLE. START in this cycle is ignored.
- Latency:
  - Normal result: DONE is high WIDTH+3 cycles after the START sampling edge (19 cycles for WIDTH=16).
  - CHECK error: DONE is high 2 cycles after START.
- START while BUSY=1 is ignored and operands are not recaptured.
- Input changes after capture have no effect.
- Unsigned arithmetic is exact; remainder < divisor. In signed mode the remainder takes the dividend's sign (truncating division).
- No back-to-back acceptance: the earliest next START is sampled in the IDLE cycle after DONE.

Decomposition:
- Shared package alu8088_pkg: state encoding (IDLE, CHECK, RUN, FIX, DONE), the WIDTH default, and a counter width of clog2(WIDTH).
- One natural sub-module, div_step: a combinational (WIDTH+1)-bit trial subtract. Inputs are prem, the incoming bit and the divisor; outputs are next prem and the quotient bit. It is reusable by a future non-restoring variant.

Test Plan:
- Unsigned: DIVIDEND=0x00000064, DIVISOR=0x0007, SIGNED=0 -> DONE 19 cycles after START, Q=0x000E, REM=0x0002, DE=0.
- Zero divisor: DIVIDEND=0x12345678, DIVISOR=0 -> DONE 2 cycles after START, DE=1, Q/REM unchanged from the previous result.
- Unsigned overflow: DIVIDEND=0x00100000, DIVISOR=0x0010, SIGNED=0 -> DE=1 at 2-cycle latency.
- Signed: DIVIDEND=0xFFFFFFF9 (-7), DIVISOR=0x0002, SIGNED=1 -> Q=0xFFFD (-3), REM=0xFFFF (-1), DE=0, latency 19.
- Signed boundary: DIVIDEND=0xFFFF8000, DIVISOR=0x0001 -> quotient -32768 gives DE=1 at latency 19. DIVIDEND=0x00007FFF, DIVISOR=0x0001 -> Q=0x7FFF, DE=0.
- Control:
  - START pulsed during RUN with different operands -> ignored, and the first result completes correctly.
  - RST asserted mid-RUN -> BUSY=DONE=DE=0, Q=REM=0 immediately, no DONE pulse.
  - A new START after reset works normally.

Source files
------------

// File: rtl/alu8088_pkg.sv
// Shared definitions for the 8088 ALU datapath blocks: divider FSM encoding,
// default datapath width and the divider bit-counter width helper.
package alu8088_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } div_state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the
// partial remainder extended by the next dividend bit.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             shift_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Partial remainder stays below the divisor, so either result fits WIDTH bits.
  assign trial     = {prem, shift_bit};
  assign diff      = trial - {1'b0, divisor};
  assign q_bit     = (trial >= {1'b0, divisor});
  assign prem_next = WIDTH'(q_bit ? diff : trial);

endmodule

// File: rtl/div_seq_8088.sv
// Sequential restoring divider for 8088 DIV/IDIV: one quotient bit per clock,
// divide-error detection up front (zero divisor, unsigned overflow) and after sign fix-up.
module div_seq_8088
  import alu8088_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 SIGNED,
  input  logic [2*WIDTH-1:0]   DIVIDEND,
  input  logic [WIDTH-1:0]     DIVISOR,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     REM,
  output logic                 DE
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;

  logic               sgn;
  logic [2*WIDTH-1:0] dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   prem;
  logic [WIDTH-1:0]   shift;
  logic               qneg;
  logic               rneg;

  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;
  logic               chk_err;
  logic               last_bit;
  logic               q_ovf;
  logic [WIDTH-1:0]   prem_next;
  logic               q_bit;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .shift_bit (shift[WIDTH-1]),
    .divisor   (dvs),
    .prem_next (prem_next),
    .q_bit     (q_bit)
  );

  // A quotient that fits WIDTH bits unsigned but has its top bit set is out of IDIV range.
  always_comb begin
    dvd_mag  = (sgn && dvd[2*WIDTH-1]) ? (~dvd + (2*WIDTH)'(1)) : dvd;
    dvs_mag  = (sgn && dvs[WIDTH-1]) ? (~dvs + WIDTH'(1)) : dvs;
    chk_err  = (dvs_mag == '0) || (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);
    last_bit = (cnt == CNT_W'(WIDTH-1));
    q_ovf    = sgn && shift[WIDTH-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = chk_err ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_bit) state_nxt = ST_FIX;
      ST_FIX:   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state != ST_IDLE);
    DONE = (state == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      Q   <= '0;
      REM <= '0;
      DE  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (START) DE <= 1'b0;
        ST_CHECK: begin
          cnt <= '0;
          if (chk_err) DE <= 1'b1;
        end
        ST_RUN:   cnt <= cnt + CNT_W'(1);
        ST_FIX: begin
          if (q_ovf) begin
            DE <= 1'b1;
          end else begin
            Q   <= neg_if(shift, qneg);
            REM <= neg_if(prem, rneg);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand and working registers carry no reset; they are always loaded before use.
  always_ff @(posedge CLK) begin
    case (state)
      ST_IDLE: begin
        if (START) begin
          sgn <= SIGNED;
          dvd <= DIVIDEND;
          dvs <= DIVISOR;
        end
      end
      ST_CHECK: begin
        dvs   <= dvs_mag;
        prem  <= dvd_mag[2*WIDTH-1:WIDTH];
        shift <= dvd_mag[WIDTH-1:0];
        qneg  <= sgn && (dvd[2*WIDTH-1] ^ dvs[WIDTH-1]);
        rneg  <= sgn && dvd[2*WIDTH-1];
      end
      ST_RUN: begin
        prem  <= prem_next;
        shift <= {shift[WIDTH-2:0], q_bit};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_seq_8088.sv
// Bench for div_seq_8088 (WIDTH=16): table vectors, random vectors against a
// behavioural divide model, and control corner cases (START while busy, reset mid-run).
module tb_div_seq_8088;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, de;
  logic [15:0] q, rem;

  always #5 clk = ~clk;

  div_seq_8088 #(.WIDTH(16)) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .SIGNED   (sgn),
    .DIVIDEND (dividend),
    .DIVISOR  (divisor),
    .BUSY     (busy),
    .DONE     (done),
    .Q        (q),
    .REM      (rem),
    .DE       (de)
  );

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic        s;
    logic [15:0] eq;
    logic [15:0] er;
    logic        ede;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] eq;
    logic [15:0] er;
    logic        ede;
    int          lat;
    int          sample_edge;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] mq = '0;
  logic [15:0] mr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done: DONE high with nothing outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(q), 32'(e.eq));
        check("remainder", 32'(rem), 32'(e.er));
        check("divide_error", 32'(de), 32'(e.ede));
        check("latency", 32'(cyc - e.sample_edge + 1), 32'(e.lat));
      end
    end
  end

  // Reference divide: exact arithmetic on 64-bit integers, truncating toward zero.
  task automatic model(input logic [31:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic ede, output int lat);
    longint na, nb, aa, ab, qa, qv, rv;
    na = s ? longint'($signed(a)) : longint'(a);
    nb = s ? longint'($signed(b)) : longint'(b);
    eq = mq;
    er = mr;
    ede = 1'b1;
    lat = 2;
    if (nb != 0) begin
      aa = (na < 0) ? -na : na;
      ab = (nb < 0) ? -nb : nb;
      qa = aa / ab;
      if (qa < 65536) begin
        lat = 19;
        if (!(s && qa >= 32768)) begin
          qv  = na / nb;
          rv  = na % nb;
          eq  = qv[15:0];
          er  = rv[15:0];
          ede = 1'b0;
        end
      end
    end
  endtask

  // Called at a negedge; START is sampled by the following posedge.
  task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ede, input int lat);
    exp_t e;
    e.eq = eq;
    e.er = er;
    e.ede = ede;
    e.lat = lat;
    e.sample_edge = cyc + 1;
    sb.push_back(e);
    if (!ede) begin
      mq = eq;
      mr = er;
    end
    dividend = a;
    divisor  = b;
    sgn      = s;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = 16'($urandom);
    sgn      = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < 62) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      n_chk++;
      n_bad++;
      $display("FAIL timeout: operation did not complete, outstanding=%0d busy=%0b", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [15:0] b, input logic s);
    logic [15:0] eq, er;
    logic ede;
    int lat;
    model(a, b, s, eq, er, ede, lat);
    issue(a, b, s, eq, er, ede, lat);
  endtask

  initial begin
    vec_t tbl[11];
    logic [31:0] a;
    logic [15:0] b;
    logic        s;
    int          n;

    tbl[0]  = '{32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 1'b0, 19};
    tbl[1]  = '{32'h1234_5678, 16'h0000, 1'b0, 16'h000E, 16'h0002, 1'b1, 2};
    tbl[2]  = '{32'h0010_0000, 16'h0010, 1'b0, 16'h000E, 16'h0002, 1'b1, 2};
    tbl[3]  = '{32'hFFFF_FFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 19};
    tbl[4]  = '{32'hFFFF_8000, 16'h0001, 1'b1, 16'hFFFD, 16'hFFFF, 1'b1, 19};
    tbl[5]  = '{32'h0000_7FFF, 16'h0001, 1'b1, 16'h7FFF, 16'h0000, 1'b0, 19};
    tbl[6]  = '{32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 1'b0, 19};
    tbl[7]  = '{32'h0000_0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 19};
    tbl[8]  = '{32'hFFFF_FFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 19};
    tbl[9]  = '{32'h0000_0000, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0, 19};
    tbl[10] = '{32'h8000_0000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b1, 2};

    rst = 1'b1;
    start = 1'b0;
    sgn = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_de", 32'(de), 32'(0));
    check("reset_q", 32'(q), 32'(0));
    check("reset_rem", 32'(rem), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].dvd, tbl[i].dvs, tbl[i].s, tbl[i].eq, tbl[i].er, tbl[i].ede, tbl[i].lat);
      wait_idle();
    end

    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      b = 16'($urandom);
      if (b == 16'h0000 && i % 6 != 5) b = 16'h0003;
      a = $urandom;
      if (s) a = {{8{a[23]}}, a[23:0]};
      else if (i % 4 != 3) a[31:16] = 16'(a[31:16] % ((b == 0) ? 16'h0001 : b));
      issue_model(a, b, s);
      wait_idle();
    end

    // START during RUN with other operands must be ignored.
    issue_model(32'h0000_1234, 16'h0011, 1'b0);
    repeat (4) @(negedge clk);
    dividend = 32'h0000_0100;
    divisor  = 16'h0002;
    sgn      = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_idle();

    // START held in the DONE cycle must not be accepted.
    issue_model(32'h0001_0000, 16'h0100, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    dividend = 32'h0000_0009;
    divisor  = 16'h0003;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'(0));
    wait_idle();

    // Asynchronous reset in the middle of RUN aborts without a DONE pulse.
    issue_model(32'h0003_0000, 16'h0007, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_de", 32'(de), 32'(0));
    check("abort_q", 32'(q), 32'(0));
    check("abort_rem", 32'(rem), 32'(0));
    sb.delete();
    mq = '0;
    mr = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("abort_idle", 32'(busy), 32'(0));

    issue_model(32'h0000_03E8, 16'h0021, 1'b0);
    wait_idle();
    issue_model(32'hFFFF_FC18, 16'h0021, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
